// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester bus plus the UART transmitter handshake.
// The master side is the arbiter. The slave side is the environment,
// which contains the requesters and the transmitter.
// timeout_err is present only when UART_ARB_TIMEOUT_EN is defined.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   ack;
  logic               busy;
  logic [ID_W-1:0]    grant_id;
  logic               tx_send;
  logic [7:0]         tx_data;
  logic               tx_active_flag;
  logic               tx_done_flag;
`ifdef UART_ARB_TIMEOUT_EN
  logic               timeout_err;
`endif

  modport master (
    input  req, req_data, tx_active_flag, tx_done_flag,
    output ack, busy, grant_id, tx_send, tx_data
`ifdef UART_ARB_TIMEOUT_EN
    , output timeout_err
`endif
  );

  modport slave (
    output req, req_data, tx_active_flag, tx_done_flag,
    input  ack, busy, grant_id, tx_send, tx_data
`ifdef UART_ARB_TIMEOUT_EN
    , input timeout_err
`endif
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between
// N_REQ byte requesters.
//
// Optional watchdog: define UART_ARB_TIMEOUT_EN. When it is defined, a frame
// that is not finished within TIMEOUT_CYCLES is abandoned. The block then
// pulses timeout_err and issues no ack.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no frame in flight; arbitrate among pending requests
// LAUNCH    | tx_send high; wait for the transmitter to report active
// WAIT_DONE | frame in flight; wait for a rising edge of tx_done_flag
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ID_W           = $clog2(N_REQ),
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input logic             clk,
  input logic             rst,
  uart_tx_arbiter_if.master bus
);

  // Elaboration-time guard against illegal parameter combinations.
  generate
    if (N_REQ < 2 || N_REQ > 16 || ID_W < $clog2(N_REQ) || TIMEOUT_CYCLES < 1) begin : g_param_err
      $error("uart_tx_arbiter: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  last, last_nxt;
  logic [ID_W-1:0]  grant_id_q, grant_nxt;
  logic [7:0]       tx_data_q, tx_data_nxt;
  logic [N_REQ-1:0] ack_q, ack_nxt;
  logic             done_q;
  logic             done_rise;
  logic             tx_send_c;

  logic             found;
  logic [ID_W-1:0]  sel;
  logic [7:0]       sel_byte;

  // The done flag may already be high when WAIT_DONE is entered.
  // Only a 0->1 transition seen against done_q counts as completion.
  assign done_rise = bus.tx_done_flag & ~done_q;

  // Round-robin search. Requesters above 'last' are searched first,
  // then requesters from 0 up to 'last', so the most recently served
  // requester is searched last.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    sel_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && (i > int'(last)) && bus.req[i]) begin
        found    = 1'b1;
        sel      = ID_W'(i);
        sel_byte = bus.req_data[8*i +: 8];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && (i <= int'(last)) && bus.req[i]) begin
        found    = 1'b1;
        sel      = ID_W'(i);
        sel_byte = bus.req_data[8*i +: 8];
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             tmo_err_q, tmo_err_nxt;

  // The counter reads 0 in the first LAUNCH cycle. The error is registered,
  // so it shows TIMEOUT_CYCLES cycles after LAUNCH entry, in the same cycle
  // that the FSM is back in IDLE.
  assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter: held at zero while idle, counts while a frame is open.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Registered one-cycle timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_err_q <= 1'b0;
    end else begin
      tmo_err_q <= tmo_err_nxt;
    end
  end

  assign bus.timeout_err = tmo_err_q;
`endif

  // Next-state, grant capture and ack generation.
  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    grant_nxt   = grant_id_q;
    tx_data_nxt = tx_data_q;
    ack_nxt     = '0;
    tx_send_c   = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    tmo_err_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt   = sel;
          tx_data_nxt = sel_byte;
          state_nxt   = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_send_c = 1'b1;
        if (bus.tx_active_flag) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (done_rise) begin
          for (int i = 0; i < N_REQ; i++) begin
            if (grant_id_q == ID_W'(i)) begin
              ack_nxt[i] = 1'b1;
            end
          end
          last_nxt  = grant_id_q;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
`ifdef UART_ARB_TIMEOUT_EN
    // If the frame completes in the same cycle as the timeout, the
    // completion wins and the requester still gets its ack.
    if (tmo_hit && !((state == WAIT_DONE) && done_rise)) begin
      state_nxt   = IDLE;
      last_nxt    = grant_id_q;
      tmo_err_nxt = 1'b1;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Priority pointer, grant/data latches, ack pulse and the done-edge history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last       <= ID_W'(N_REQ - 1);
      grant_id_q <= '0;
      tx_data_q  <= 8'h00;
      ack_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      last       <= last_nxt;
      grant_id_q <= grant_nxt;
      tx_data_q  <= tx_data_nxt;
      ack_q      <= ack_nxt;
      done_q     <= bus.tx_done_flag;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.busy     = (state != IDLE);
  assign bus.grant_id = grant_id_q;
  assign bus.tx_send  = tx_send_c;
  assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed, self-checking bench for uart_tx_arbiter.
// The bench plays both the requesters and the transmitter.
// Build with UART_ARB_TIMEOUT_EN defined to also exercise the watchdog.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  uart_tx_arbiter_if #(.N_REQ(N)) bus();

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // observations returned by xmit
  int         lat;
  logic [1:0] gid;
  logic [7:0] dat;
  logic       held;
  logic       fell;
  logic [3:0] ackv;
  logic       busyv;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.req_data = '0;
    bus.tx_active_flag = 1'b0;
    bus.tx_done_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Transmitter model for one frame. It records what it observes and
  // checks nothing; the calling test compares the observations.
  task automatic xmit(input bit drop);
    lat = 0;
    while (bus.tx_send !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    gid = bus.grant_id;
    dat = bus.tx_data;
    if (drop) bus.req = '0;
    step();
    held = bus.tx_send;
    bus.tx_active_flag = 1'b1;
    step();
    fell = bus.tx_send;
    step();
    step();
    bus.tx_active_flag = 1'b0;
    bus.tx_done_flag = 1'b1;
    step();
    ackv = bus.ack;
    busyv = bus.busy;
    bus.tx_done_flag = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (bus.ack !== 4'b0000) begin miscompares++; $display("FAIL reset_ack: got %b expected 0000", bus.ack); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.grant_id !== 2'd0) begin miscompares++; $display("FAIL reset_grant: got %0d expected 0", bus.grant_id); end
    vectors++; if (bus.tx_send !== 1'b0) begin miscompares++; $display("FAIL reset_send: got %b expected 0", bus.tx_send); end
    vectors++; if (bus.tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h expected 00", bus.tx_data); end
  endtask

  task automatic test_single();
    bus.req_data = 32'h0000_00A5;
    bus.req = 4'b0001;
    xmit(1'b0);
    bus.req = '0;
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL single_latency: got %0d expected 1", lat); end
    vectors++; if (dat !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %h expected a5", dat); end
    vectors++; if (gid !== 2'd0) begin miscompares++; $display("FAIL single_grant: got %0d expected 0", gid); end
    vectors++; if (held !== 1'b1) begin miscompares++; $display("FAIL single_send_held: got %b expected 1", held); end
    vectors++; if (fell !== 1'b0) begin miscompares++; $display("FAIL single_send_fall: got %b expected 0", fell); end
    vectors++; if (ackv !== 4'b0001) begin miscompares++; $display("FAIL single_ack: got %b expected 0001", ackv); end
    vectors++; if (busyv !== 1'b0) begin miscompares++; $display("FAIL single_busy_at_ack: got %b expected 0", busyv); end
    step();
    vectors++; if (bus.ack !== 4'b0000) begin miscompares++; $display("FAIL single_ack_width: got %b expected 0000", bus.ack); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL single_idle: got %b expected 0", bus.busy); end
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    bus.req_data = 32'h1312_1110;
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      xmit(1'b0);
      vectors++; if (gid !== 2'(exp_order[i])) begin miscompares++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", i, gid, exp_order[i]); end
      vectors++; if (dat !== 8'(8'h10 + exp_order[i])) begin miscompares++; $display("FAIL rr_data[%0d]: got %h expected %h", i, dat, 8'(8'h10 + exp_order[i])); end
      vectors++; if (ackv !== 4'(1 << exp_order[i])) begin miscompares++; $display("FAIL rr_ack[%0d]: got %b expected %b", i, ackv, 4'(1 << exp_order[i])); end
      vectors++; if (lat !== 1) begin miscompares++; $display("FAIL rr_latency[%0d]: got %0d expected 1", i, lat); end
    end
    bus.req = '0;
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.req_data = 32'hD4C3_B2A1;
    bus.req = 4'b0100;
    xmit(1'b0);
    vectors++; if (gid !== 2'd2) begin miscompares++; $display("FAIL wrap_first: got %0d expected 2", gid); end
    bus.req = 4'b0101;
    xmit(1'b0);
    vectors++; if (gid !== 2'd0) begin miscompares++; $display("FAIL wrap_second: got %0d expected 0", gid); end
    vectors++; if (dat !== 8'hA1) begin miscompares++; $display("FAIL wrap_second_data: got %h expected a1", dat); end
    xmit(1'b0);
    vectors++; if (gid !== 2'd2) begin miscompares++; $display("FAIL wrap_third: got %0d expected 2", gid); end
    vectors++; if (dat !== 8'hC3) begin miscompares++; $display("FAIL wrap_third_data: got %h expected c3", dat); end
    bus.req = '0;
    step();
  endtask

  task automatic test_drop_req();
    do_reset();
    bus.req_data = 32'h0000_5A00;
    bus.req = 4'b0010;
    xmit(1'b1);
    vectors++; if (gid !== 2'd1) begin miscompares++; $display("FAIL drop_grant: got %0d expected 1", gid); end
    vectors++; if (dat !== 8'h5A) begin miscompares++; $display("FAIL drop_data: got %h expected 5a", dat); end
    vectors++; if (ackv !== 4'b0010) begin miscompares++; $display("FAIL drop_ack: got %b expected 0010", ackv); end
    step();
  endtask

  task automatic test_done_already_high();
    do_reset();
    bus.req_data = 32'h0000_0077;
    bus.req = 4'b0001;
    step();
    bus.tx_active_flag = 1'b1;
    bus.tx_done_flag = 1'b1;
    step();
    step();
    step();
    vectors++; if (bus.ack !== 4'b0000) begin miscompares++; $display("FAIL done_high_no_ack: got %b expected 0000", bus.ack); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL done_high_busy: got %b expected 1", bus.busy); end
    bus.tx_done_flag = 1'b0;
    step();
    bus.tx_done_flag = 1'b1;
    step();
    vectors++; if (bus.ack !== 4'b0001) begin miscompares++; $display("FAIL done_high_ack: got %b expected 0001", bus.ack); end
    bus.tx_done_flag = 1'b0;
    bus.tx_active_flag = 1'b0;
    bus.req = '0;
    step();
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    bus.req_data = 32'h3300_0011;
    bus.req = 4'b0001;
    step();
    bus.tx_active_flag = 1'b1;
    step();
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL midrst_pre_busy: got %b expected 1", bus.busy); end
    rst = 1'b1;
    #1;
    vectors++; if (bus.tx_send !== 1'b0) begin miscompares++; $display("FAIL midrst_send: got %b expected 0", bus.tx_send); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.ack !== 4'b0000) begin miscompares++; $display("FAIL midrst_ack: got %b expected 0000", bus.ack); end
    bus.tx_active_flag = 1'b0;
    bus.req = '0;
    step();
    step();
    rst = 1'b0;
    // a stray done pulse while idle must not produce an ack
    bus.tx_done_flag = 1'b1;
    step();
    vectors++; if (bus.ack !== 4'b0000) begin miscompares++; $display("FAIL midrst_stale_ack: got %b expected 0000", bus.ack); end
    bus.tx_done_flag = 1'b0;
    step();
    bus.req = 4'b1000;
    xmit(1'b0);
    vectors++; if (gid !== 2'd3) begin miscompares++; $display("FAIL midrst_grant: got %0d expected 3", gid); end
    vectors++; if (dat !== 8'h33) begin miscompares++; $display("FAIL midrst_data: got %h expected 33", dat); end
    vectors++; if (ackv !== 4'b1000) begin miscompares++; $display("FAIL midrst_ack_after: got %b expected 1000", ackv); end
    bus.req = '0;
    step();
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    do_reset();
    bus.req_data = 32'h0000_BBAA;
    bus.req = 4'b0011;
    step();
    vectors++; if (bus.tx_send !== 1'b1) begin miscompares++; $display("FAIL tmo_launch: got %b expected 1", bus.tx_send); end
    n = 0;
    while (bus.timeout_err !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    vectors++; if (n !== 100) begin miscompares++; $display("FAIL tmo_cycles: got %0d expected 100", n); end
    vectors++; if (bus.ack !== 4'b0000) begin miscompares++; $display("FAIL tmo_no_ack: got %b expected 0000", bus.ack); end
    vectors++; if (bus.tx_send !== 1'b0) begin miscompares++; $display("FAIL tmo_send: got %b expected 0", bus.tx_send); end
    step();
    vectors++; if (bus.timeout_err !== 1'b0) begin miscompares++; $display("FAIL tmo_pulse_width: got %b expected 0", bus.timeout_err); end
    vectors++; if (bus.grant_id !== 2'd1) begin miscompares++; $display("FAIL tmo_next_grant: got %0d expected 1", bus.grant_id); end
    vectors++; if (bus.tx_data !== 8'hBB) begin miscompares++; $display("FAIL tmo_next_data: got %h expected bb", bus.tx_data); end
    bus.req = '0;
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.req = '0;
    bus.req_data = '0;
    bus.tx_active_flag = 1'b0;
    bus.tx_done_flag = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_drop_req();
    test_done_already_high();
    test_reset_mid_frame();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
